// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush and data-memory freeze; controls are combinational (0-cycle), no backpressure.
// HAZARD_PERF_EN defined adds the perf_stall/perf_flush/perf_memwait counters; undefined ties them to 0.
module hazard_ctrl #(
    parameter int N              = 32,
    parameter int REG_BITS       = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        if_id_instr,
    input  logic                id_ex_mem_read,
    input  logic [REG_BITS-1:0] id_ex_rt,
    input  logic                branch_taken,
    input  logic                dmem_busy,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_hold,
    output logic                id_ex_bubble,
    output logic                id_ex_hold,
    output logic                mem_timeout,
    output logic [1:0]          state_o,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_flush,
    output logic [31:0]         perf_memwait
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_STALL    = 2'd1,
        S_FLUSH    = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_t;

    localparam int CNT_W  = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]   wait_inc;
    logic                mem_timeout_q, mem_timeout_d;

    logic [5:0]          opcode;
    logic [REG_BITS-1:0] rs, rt;
    logic                uses_rt;
    logic                load_use;
    logic                do_freeze, do_flush, do_stall;
    logic                unused_instr;

    assign opcode       = if_id_instr[31:26];
    assign rs           = if_id_instr[21 +: REG_BITS];
    assign rt           = if_id_instr[16 +: REG_BITS];
    assign unused_instr = ^if_id_instr[15:0];

    assign uses_rt  = (opcode == 6'h00) || (opcode == 6'h04) ||
                      (opcode == 6'h05) || (opcode == 6'h2B);
    assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                      ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        flush_cnt_d = flush_cnt_q;
        do_freeze   = 1'b0;
        do_flush    = 1'b0;
        do_stall    = 1'b0;
        case (state_q)
            S_RUN, S_STALL: begin
                if (dmem_busy) begin
                    do_freeze = 1'b1;
                    state_d   = S_MEM_WAIT;
                    ret_d     = S_RUN;
                end else if (branch_taken) begin
                    do_flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = CNT_W'(BRANCH_PENALTY - 1);
                    end else begin
                        state_d = S_RUN;
                    end
                end else if ((state_q == S_RUN) && load_use) begin
                    do_stall = 1'b1;
                    state_d  = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (dmem_busy) begin
                    do_freeze = 1'b1;
                    state_d   = S_MEM_WAIT;
                    ret_d     = S_FLUSH;
                end else begin
                    do_flush = 1'b1;
                    if (branch_taken) begin
                        flush_cnt_d = CNT_W'(BRANCH_PENALTY - 1);
                    end else if (flush_cnt_q == CNT_W'(1)) begin
                        state_d = S_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    end
                end
            end
            S_MEM_WAIT: begin
                // Freeze holds through the cycle busy drops; the return happens on the next edge.
                do_freeze = 1'b1;
                if (!dmem_busy) begin
                    state_d = ret_q;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (do_freeze) begin
            pc_write   = 1'b0;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
        end else if (do_flush) begin
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (do_stall) begin
            pc_write     = 1'b0;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign wait_inc = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (state_q == S_MEM_WAIT) begin
            if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
            if (dmem_busy) begin
                wait_cnt_d = wait_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            ret_q         <= S_RUN;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state_o     = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_memwait_q, perf_memwait_d;

    always_comb begin
        perf_stall_d   = perf_stall_q + {31'd0, do_stall};
        perf_flush_d   = perf_flush_q + {31'd0, do_flush};
        perf_memwait_d = perf_memwait_q + {31'd0, do_freeze};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`else
    assign perf_stall   = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule
